// File: rtl/ma_pkg.sv
// Shared definitions for the memory-access (MA) pipeline stage:
// control-bus bit positions, addressing and exception codes, FSM encoding.
package ma_pkg;

  // Bit positions inside the combined {MA, WB} control bus
  localparam int CTL_MEM_READ   = 6;
  localparam int CTL_MEM_WRITE  = 5;
  localparam int CTL_ADDR_HI    = 4;
  localparam int CTL_ADDR_LO    = 3;
  localparam int CTL_SIGNING    = 2;
  localparam int CTL_MEM_TO_REG = 1;
  localparam int CTL_REG_WRITE  = 0;

  typedef enum logic [1:0] {
    ADDR_BYTE     = 2'b00,
    ADDR_HALF     = 2'b01,
    ADDR_WORD_ALT = 2'b10,
    ADDR_WORD     = 2'b11
  } addressing_e;

  typedef enum logic [1:0] {
    EXC_NONE        = 2'b00,
    EXC_MISALIGN_LD = 2'b01,
    EXC_MISALIGN_ST = 2'b10,
    EXC_BUS         = 2'b11
  } exc_code_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } ma_state_e;

  // Half accesses need an even address, word accesses (including code 10) a 4-byte aligned one
  function automatic logic is_misaligned(input logic [1:0] addressing, input logic [1:0] ofs);
    logic mis;
    case (addressing)
      ADDR_BYTE: mis = 1'b0;
      ADDR_HALF: mis = ofs[0];
      default:   mis = (ofs != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ma_lane_align.sv
// Byte-lane steering for stores and lane extraction / extension for loads.
// Purely combinational; the store side and the load side have independent
// inputs because stores are steered before the access and loads after it.
module ma_lane_align
  import ma_pkg::*;
#(
  parameter int NB_DATA = 32,
  localparam int NB_BE  = NB_DATA / 8,
  localparam int NB_OFS = $clog2(NB_BE)
) (
  input  logic [1:0]         i_st_addressing,
  input  logic [NB_OFS-1:0]  i_st_ofs,
  input  logic [NB_DATA-1:0] i_st_data,
  output logic [NB_DATA-1:0] o_st_wdata,
  output logic [NB_BE-1:0]   o_st_be,
  input  logic [1:0]         i_ld_addressing,
  input  logic [NB_OFS-1:0]  i_ld_ofs,
  input  logic               i_ld_signing,
  input  logic [NB_DATA-1:0] i_ld_rdata,
  output logic [NB_DATA-1:0] o_ld_data
);

  logic [NB_DATA-1:0] ld_shifted_s;

  // Store steering: replicate the narrow datum on every lane, enable only the addressed lanes
  always_comb begin
    o_st_wdata = i_st_data;
    o_st_be    = {NB_BE{1'b1}};
    case (i_st_addressing)
      ADDR_BYTE: begin
        o_st_wdata = {NB_BE{i_st_data[7:0]}};
        o_st_be    = {{(NB_BE-1){1'b0}}, 1'b1} << i_st_ofs;
      end
      ADDR_HALF: begin
        o_st_wdata = {(NB_BE/2){i_st_data[15:0]}};
        o_st_be    = {{(NB_BE-2){1'b0}}, 2'b11} << {i_st_ofs[NB_OFS-1:1], 1'b0};
      end
      default: begin
        o_st_wdata = i_st_data;
        o_st_be    = {NB_BE{1'b1}};
      end
    endcase
  end

  assign ld_shifted_s = i_ld_rdata >> {i_ld_ofs, 3'b000};

  // Load extraction: bring the addressed lane to bit 0, then sign- or zero-extend
  always_comb begin
    o_ld_data = ld_shifted_s;
    case (i_ld_addressing)
      ADDR_BYTE: begin
        if (i_ld_signing) begin
          o_ld_data = {{(NB_DATA-8){ld_shifted_s[7]}}, ld_shifted_s[7:0]};
        end else begin
          o_ld_data = {{(NB_DATA-8){1'b0}}, ld_shifted_s[7:0]};
        end
      end
      ADDR_HALF: begin
        if (i_ld_signing) begin
          o_ld_data = {{(NB_DATA-16){ld_shifted_s[15]}}, ld_shifted_s[15:0]};
        end else begin
          o_ld_data = {{(NB_DATA-16){1'b0}}, ld_shifted_s[15:0]};
        end
      end
      default: o_ld_data = i_ld_rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_hs.sv
// MIPS MA stage with a req/ack data-memory port. Aligned memory operations
// stall upstream until the memory acknowledges; misaligned ones and bus
// errors become registered exceptions in the MA/WB register.
module memory_access_hs
  import ma_pkg::*;
#(
  parameter int NB_DATA           = 32,
  parameter int NB_ADDR_REGISTERS = 5,
  parameter int NB_ADDR_MEM       = 32,
  parameter int NB_CONTROL_MA     = 5,
  parameter int NB_CONTROL_WB     = 2,
  parameter int NB_CONTROL_MA_WB  = NB_CONTROL_MA + NB_CONTROL_WB,
  localparam int NB_BE            = NB_DATA / 8,
  localparam int NB_OFS           = $clog2(NB_BE)
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_valid,
  input  logic [NB_CONTROL_MA_WB-1:0]  i_control_ma_wb,
  input  logic [NB_DATA-1:0]           i_mem_addr,
  input  logic [NB_DATA-1:0]           i_mem_data,
  input  logic [NB_ADDR_REGISTERS-1:0] i_rd_num,
  output logic                         o_stall,
  output logic                         o_bus_req,
  output logic                         o_bus_we,
  output logic [NB_ADDR_MEM-1:0]       o_bus_addr,
  output logic [NB_DATA-1:0]           o_bus_wdata,
  output logic [NB_BE-1:0]             o_bus_be,
  input  logic                         i_bus_ack,
  input  logic [NB_DATA-1:0]           i_bus_rdata,
  input  logic                         i_bus_err,
  output logic                         o_valid_wb,
  output logic [NB_CONTROL_WB-1:0]     o_control_wb,
  output logic [NB_DATA-1:0]           o_mem_r_data,
  output logic [NB_DATA-1:0]           o_reg_data,
  output logic [NB_ADDR_REGISTERS-1:0] o_reg_num,
  output logic                         o_exc,
  output logic [1:0]                   o_exc_code,
  output logic [NB_ADDR_REGISTERS-1:0] o_ex_rd_num,
  output logic                         o_ex_ctl_reg_write,
  output logic [NB_DATA-1:0]           o_ex_rd_data
);

  // Decoded control of the instruction currently in EX/MA
  logic                     mem_read_s, mem_write_s, is_mem_s, misaligned_s, exc_s;
  logic [1:0]               addressing_s;
  logic [NB_CONTROL_WB-1:0] ctl_wb_s;
  logic [NB_ADDR_MEM-1:0]   word_addr_s;
  logic [NB_DATA-1:0]       st_wdata_s, ld_data_s;
  logic [NB_BE-1:0]         st_be_s;

  // FSM
  ma_state_e state_r, next_state_s;
  logic      stall_s, start_s, wb_load_s, wb_from_bus_s;

  // Fields latched for the duration of an access
  logic [NB_DATA-1:0]           lat_addr_r;
  logic [1:0]                   lat_addressing_r;
  logic                         lat_signing_r;
  logic [NB_CONTROL_WB-1:0]     lat_ctl_wb_r;
  logic [NB_ADDR_REGISTERS-1:0] lat_rd_r;

  // Bus and MA/WB registers
  logic                         bus_req_r, bus_we_r;
  logic [NB_ADDR_MEM-1:0]       bus_addr_r;
  logic [NB_DATA-1:0]           bus_wdata_r;
  logic [NB_BE-1:0]             bus_be_r;
  logic                         valid_wb_r, exc_r;
  logic [NB_CONTROL_WB-1:0]     control_wb_r;
  logic [NB_DATA-1:0]           mem_r_data_r, reg_data_r;
  logic [NB_ADDR_REGISTERS-1:0] reg_num_r;
  logic [1:0]                   exc_code_r;

  assign mem_read_s   = i_control_ma_wb[CTL_MEM_READ];
  assign mem_write_s  = i_control_ma_wb[CTL_MEM_WRITE];
  assign addressing_s = i_control_ma_wb[CTL_ADDR_HI:CTL_ADDR_LO];
  assign ctl_wb_s     = i_control_ma_wb[NB_CONTROL_WB-1:0];
  assign is_mem_s     = mem_read_s | mem_write_s;
  assign misaligned_s = is_misaligned(addressing_s, i_mem_addr[1:0]);
  assign exc_s        = i_valid & is_mem_s & misaligned_s;
  assign word_addr_s  = {i_mem_addr[NB_ADDR_MEM-1:NB_OFS], {NB_OFS{1'b0}}};

  ma_lane_align #(.NB_DATA(NB_DATA)) u_lane_align (
    .i_st_addressing (addressing_s),
    .i_st_ofs        (i_mem_addr[NB_OFS-1:0]),
    .i_st_data       (i_mem_data),
    .o_st_wdata      (st_wdata_s),
    .o_st_be         (st_be_s),
    .i_ld_addressing (lat_addressing_r),
    .i_ld_ofs        (lat_addr_r[NB_OFS-1:0]),
    .i_ld_signing    (lat_signing_r),
    .i_ld_rdata      (i_bus_rdata),
    .o_ld_data       (ld_data_s)
  );

  // FSM state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next state, stall and MA/WB load selection
  always_comb begin
    next_state_s  = state_r;
    stall_s       = 1'b0;
    start_s       = 1'b0;
    wb_load_s     = 1'b0;
    wb_from_bus_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_valid && is_mem_s && !misaligned_s) begin
          stall_s      = 1'b1;
          start_s      = 1'b1;
          next_state_s = ST_REQ;
        end else begin
          wb_load_s    = 1'b1;
        end
      end
      ST_REQ: begin
        if (i_bus_ack) begin
          wb_from_bus_s = 1'b1;
          next_state_s  = ST_IDLE;
        end else begin
          stall_s       = 1'b1;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Bus request, access latches and MA/WB pipeline register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bus_req_r        <= 1'b0;
      bus_we_r         <= 1'b0;
      bus_addr_r       <= '0;
      bus_wdata_r      <= '0;
      bus_be_r         <= '0;
      lat_addr_r       <= '0;
      lat_addressing_r <= 2'b00;
      lat_signing_r    <= 1'b0;
      lat_ctl_wb_r     <= '0;
      lat_rd_r         <= '0;
      valid_wb_r       <= 1'b0;
      control_wb_r     <= '0;
      mem_r_data_r     <= '0;
      reg_data_r       <= '0;
      reg_num_r        <= '0;
      exc_r            <= 1'b0;
      exc_code_r       <= EXC_NONE;
    end else if (start_s) begin
      bus_req_r        <= 1'b1;
      bus_we_r         <= mem_write_s;
      bus_addr_r       <= word_addr_s;
      bus_wdata_r      <= st_wdata_s;
      bus_be_r         <= st_be_s;
      lat_addr_r       <= i_mem_addr;
      lat_addressing_r <= addressing_s;
      lat_signing_r    <= i_control_ma_wb[CTL_SIGNING];
      lat_ctl_wb_r     <= ctl_wb_s;
      lat_rd_r         <= i_rd_num;
      valid_wb_r       <= 1'b0;
    end else if (wb_from_bus_s) begin
      bus_req_r        <= 1'b0;
      bus_we_r         <= 1'b0;
      bus_be_r         <= '0;
      valid_wb_r       <= 1'b1;
      mem_r_data_r     <= ld_data_s;
      reg_data_r       <= lat_addr_r;
      reg_num_r        <= lat_rd_r;
      exc_r            <= i_bus_err;
      if (i_bus_err) begin
        control_wb_r   <= {lat_ctl_wb_r[NB_CONTROL_WB-1:1], 1'b0};
        exc_code_r     <= EXC_BUS;
      end else begin
        control_wb_r   <= lat_ctl_wb_r;
        exc_code_r     <= EXC_NONE;
      end
    end else if (wb_load_s) begin
      valid_wb_r       <= i_valid;
      mem_r_data_r     <= '0;
      reg_data_r       <= i_mem_addr;
      reg_num_r        <= i_rd_num;
      exc_r            <= exc_s;
      if (exc_s) begin
        control_wb_r   <= {ctl_wb_s[NB_CONTROL_WB-1:1], 1'b0};
        exc_code_r     <= mem_write_s ? EXC_MISALIGN_ST : EXC_MISALIGN_LD;
      end else begin
        control_wb_r   <= ctl_wb_s;
        exc_code_r     <= EXC_NONE;
      end
    end else begin
      // Waiting for ack: MA/WB carries a bubble, bus outputs hold
      valid_wb_r       <= 1'b0;
    end
  end

  assign o_stall            = stall_s;
  assign o_bus_req          = bus_req_r;
  assign o_bus_we           = bus_we_r;
  assign o_bus_addr         = bus_addr_r;
  assign o_bus_wdata        = bus_wdata_r;
  assign o_bus_be           = bus_be_r;
  assign o_valid_wb         = valid_wb_r;
  assign o_control_wb       = control_wb_r;
  assign o_mem_r_data       = mem_r_data_r;
  assign o_reg_data         = reg_data_r;
  assign o_reg_num          = reg_num_r;
  assign o_exc              = exc_r;
  assign o_exc_code         = exc_code_r;

  // Forwarding to the EX short-circuit unit: loads cannot forward from MA
  assign o_ex_rd_num        = i_rd_num;
  assign o_ex_ctl_reg_write = i_valid & i_control_ma_wb[CTL_REG_WRITE] & ~mem_read_s;
  assign o_ex_rd_data       = i_mem_addr;

endmodule

// File: tb/tb_memory_access_hs.sv
// Scoreboard bench for memory_access_hs: expected write-back results are
// queued at issue time and compared by a monitor whenever o_valid_wb is high.
module tb_memory_access_hs;

  logic        i_clk, i_reset_n, i_valid;
  logic [6:0]  i_control_ma_wb;
  logic [31:0] i_mem_addr, i_mem_data;
  logic [4:0]  i_rd_num;
  logic        o_stall, o_bus_req, o_bus_we;
  logic [31:0] o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic        i_bus_ack, i_bus_err;
  logic [31:0] i_bus_rdata;
  logic        o_valid_wb;
  logic [1:0]  o_control_wb;
  logic [31:0] o_mem_r_data, o_reg_data;
  logic [4:0]  o_reg_num;
  logic        o_exc;
  logic [1:0]  o_exc_code;
  logic [4:0]  o_ex_rd_num;
  logic        o_ex_ctl_reg_write;
  logic [31:0] o_ex_rd_data;

  memory_access_hs dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid),
    .i_control_ma_wb(i_control_ma_wb), .i_mem_addr(i_mem_addr),
    .i_mem_data(i_mem_data), .i_rd_num(i_rd_num), .o_stall(o_stall),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
    .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be), .i_bus_ack(i_bus_ack),
    .i_bus_rdata(i_bus_rdata), .i_bus_err(i_bus_err), .o_valid_wb(o_valid_wb),
    .o_control_wb(o_control_wb), .o_mem_r_data(o_mem_r_data),
    .o_reg_data(o_reg_data), .o_reg_num(o_reg_num), .o_exc(o_exc),
    .o_exc_code(o_exc_code), .o_ex_rd_num(o_ex_rd_num),
    .o_ex_ctl_reg_write(o_ex_ctl_reg_write), .o_ex_rd_data(o_ex_rd_data)
  );

  typedef struct {
    logic [1:0]  ctl;
    logic [31:0] rdata;
    logic        chk_rdata;
    logic [31:0] reg_data;
    logic [4:0]  rd;
    logic        exc;
    logic [1:0]  code;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Observations captured while an operation is being issued
  int          stall_cyc, req_cyc;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_be;
  logic        seen_we, fwd_rw;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] ctl, input logic [31:0] rdata, input logic chk,
                          input logic [31:0] reg_data, input logic [4:0] rd,
                          input logic exc, input logic [1:0] code);
    exp_t e;
    e.ctl = ctl; e.rdata = rdata; e.chk_rdata = chk; e.reg_data = reg_data;
    e.rd = rd; e.exc = exc; e.code = code;
    exp_q.push_back(e);
  endtask

  // Monitor: every valid write-back must match the oldest expected entry
  always @(negedge i_clk) begin : monitor
    exp_t e;
    if (i_reset_n === 1'b1 && o_valid_wb === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wb_unexpected: got valid write-back reg_data 0x%08h, expected none", o_reg_data);
      end else begin
        e = exp_q.pop_front();
        check("wb_ctl",      32'(o_control_wb), 32'(e.ctl));
        check("wb_reg_data", o_reg_data,        e.reg_data);
        check("wb_reg_num",  32'(o_reg_num),    32'(e.rd));
        check("wb_exc",      32'(o_exc),        32'(e.exc));
        check("wb_exc_code", 32'(o_exc_code),   32'(e.code));
        if (e.chk_rdata) check("wb_mem_r_data", o_mem_r_data, e.rdata);
      end
    end
  end

  // Issue one instruction, answering the bus after ack_wait unacknowledged REQ cycles
  task automatic do_op(input logic v, input logic [6:0] ctl, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] rd, input int ack_wait,
                       input logic [31:0] rdata, input logic err);
    bit done = 1'b0;
    i_valid = v; i_control_ma_wb = ctl; i_mem_addr = addr; i_mem_data = data;
    i_rd_num = rd; i_bus_ack = 1'b0; i_bus_err = 1'b0;
    stall_cyc = 0; req_cyc = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (c == 0) begin
        fwd_rw = o_ex_ctl_reg_write; fwd_rd = o_ex_rd_num; fwd_data = o_ex_rd_data;
      end
      if (o_bus_req) begin
        if (req_cyc == 0) begin
          seen_addr = o_bus_addr; seen_wdata = o_bus_wdata;
          seen_be = o_bus_be; seen_we = o_bus_we;
        end
        if (req_cyc == ack_wait) begin
          i_bus_ack = 1'b1; i_bus_rdata = rdata; i_bus_err = err;
        end
        req_cyc++;
      end
      #1;
      if (o_stall) stall_cyc++;
      else done = 1'b1;
      @(posedge i_clk);
      #1;
      i_bus_ack = 1'b0; i_bus_err = 1'b0;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL op_timeout: got stall still high after 40 cycles, expected completion");
    end
    i_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset_n = 1'b0; i_valid = 1'b0; i_control_ma_wb = 7'b0; i_mem_addr = 32'h0;
    i_mem_data = 32'h0; i_rd_num = 5'd0; i_bus_ack = 1'b0; i_bus_rdata = 32'h0;
    i_bus_err = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_bus_req",    32'(o_bus_req),    32'h0);
    check("rst_bus_we",     32'(o_bus_we),     32'h0);
    check("rst_bus_be",     32'(o_bus_be),     32'h0);
    check("rst_bus_addr",   o_bus_addr,        32'h0);
    check("rst_valid_wb",   32'(o_valid_wb),   32'h0);
    check("rst_control_wb", 32'(o_control_wb), 32'h0);
    check("rst_exc",        32'(o_exc),        32'h0);
    check("rst_exc_code",   32'(o_exc_code),   32'h0);
    check("rst_reg_data",   o_reg_data,        32'h0);
    check("rst_mem_r_data", o_mem_r_data,      32'h0);
    check("rst_stall",      32'(o_stall),      32'h0);
    i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;

    // ALU op: single-cycle pass-through, forwarding enabled
    push_exp(2'b01, 32'h0, 1'b0, 32'h00001234, 5'd5, 1'b0, 2'b00);
    do_op(1'b1, 7'b0000001, 32'h00001234, 32'h0, 5'd5, 0, 32'h0, 1'b0);
    check("alu_stall",  32'(stall_cyc), 32'd0);
    check("alu_fwd_rw", 32'(fwd_rw),    32'h1);
    check("alu_fwd_rd", 32'(fwd_rd),    32'd5);
    check("alu_fwd_data", fwd_data,     32'h00001234);

    // Word load, ack in the fourth REQ cycle
    push_exp(2'b11, 32'hDEADBEEF, 1'b1, 32'h00000040, 5'd8, 1'b0, 2'b00);
    do_op(1'b1, 7'b1011011, 32'h00000040, 32'h0, 5'd8, 3, 32'hDEADBEEF, 1'b0);
    check("lw_stall",     32'(stall_cyc), 32'd4);
    check("lw_bus_addr",  seen_addr,      32'h00000040);
    check("lw_bus_we",    32'(seen_we),   32'h0);
    check("lw_fwd_rw",    32'(fwd_rw),    32'h0);

    // Byte / half loads from 0x80112233
    push_exp(2'b11, 32'hFFFFFF80, 1'b1, 32'h00000043, 5'd9, 1'b0, 2'b00);
    do_op(1'b1, 7'b1000111, 32'h00000043, 32'h0, 5'd9, 0, 32'h80112233, 1'b0);
    check("lb_min_latency_stall", 32'(stall_cyc), 32'd1);
    check("lb_bus_addr", seen_addr, 32'h00000040);
    push_exp(2'b11, 32'h00000080, 1'b1, 32'h00000043, 5'd10, 1'b0, 2'b00);
    do_op(1'b1, 7'b1000011, 32'h00000043, 32'h0, 5'd10, 0, 32'h80112233, 1'b0);
    push_exp(2'b11, 32'hFFFF8011, 1'b1, 32'h00000042, 5'd11, 1'b0, 2'b00);
    do_op(1'b1, 7'b1001111, 32'h00000042, 32'h0, 5'd11, 1, 32'h80112233, 1'b0);
    push_exp(2'b11, 32'h00000022, 1'b1, 32'h00000041, 5'd12, 1'b0, 2'b00);
    do_op(1'b1, 7'b1000011, 32'h00000041, 32'h0, 5'd12, 0, 32'h80112233, 1'b0);

    // Stores: half, byte, word, and read+write treated as write
    push_exp(2'b00, 32'h0, 1'b0, 32'h00000012, 5'd0, 1'b0, 2'b00);
    do_op(1'b1, 7'b0101000, 32'h00000012, 32'h0000ABCD, 5'd0, 1, 32'h0, 1'b0);
    check("sh_be",    32'(seen_be),   32'hC);
    check("sh_wdata", seen_wdata,     32'hABCDABCD);
    check("sh_we",    32'(seen_we),   32'h1);
    check("sh_addr",  seen_addr,      32'h00000010);
    check("sh_stall", 32'(stall_cyc), 32'd2);
    push_exp(2'b00, 32'h0, 1'b0, 32'h00000021, 5'd0, 1'b0, 2'b00);
    do_op(1'b1, 7'b0100000, 32'h00000021, 32'h0000005A, 5'd0, 0, 32'h0, 1'b0);
    check("sb_be",    32'(seen_be), 32'h2);
    check("sb_wdata", seen_wdata,   32'h5A5A5A5A);
    push_exp(2'b00, 32'h0, 1'b0, 32'h00000030, 5'd0, 1'b0, 2'b00);
    do_op(1'b1, 7'b0111000, 32'h00000030, 32'h01020304, 5'd0, 0, 32'h0, 1'b0);
    check("sw_be",    32'(seen_be), 32'hF);
    check("sw_wdata", seen_wdata,   32'h01020304);
    push_exp(2'b00, 32'h0, 1'b0, 32'h00000050, 5'd0, 1'b0, 2'b00);
    do_op(1'b1, 7'b1111000, 32'h00000050, 32'h11223344, 5'd0, 0, 32'h0, 1'b0);
    check("rw_we", 32'(seen_we), 32'h1);

    // Misaligned accesses: no request, exception, reg_write cleared
    push_exp(2'b10, 32'h0, 1'b0, 32'h00000041, 5'd7, 1'b1, 2'b01);
    do_op(1'b1, 7'b1011011, 32'h00000041, 32'h0, 5'd7, 0, 32'h0, 1'b0);
    check("mis_lw_req",   32'(req_cyc),   32'd0);
    check("mis_lw_stall", 32'(stall_cyc), 32'd0);
    push_exp(2'b00, 32'h0, 1'b0, 32'h00000013, 5'd0, 1'b1, 2'b10);
    do_op(1'b1, 7'b0101000, 32'h00000013, 32'h0000BEEF, 5'd0, 0, 32'h0, 1'b0);
    check("mis_sh_req", 32'(req_cyc), 32'd0);
    push_exp(2'b10, 32'h0, 1'b0, 32'h00000042, 5'd6, 1'b1, 2'b01);
    do_op(1'b1, 7'b1010011, 32'h00000042, 32'h0, 5'd6, 0, 32'h0, 1'b0);
    check("mis_alt_word_req", 32'(req_cyc), 32'd0);

    // Bus error on a load
    push_exp(2'b10, 32'h0, 1'b0, 32'h00000044, 5'd3, 1'b1, 2'b11);
    do_op(1'b1, 7'b1011011, 32'h00000044, 32'h0, 5'd3, 0, 32'h12345678, 1'b1);

    // Invalid memory op: nothing happens
    do_op(1'b0, 7'b1011011, 32'h00000048, 32'h0, 5'd4, 0, 32'h0, 1'b0);
    check("inv_req",    32'(req_cyc),   32'd0);
    check("inv_stall",  32'(stall_cyc), 32'd0);
    check("inv_fwd_rw", 32'(fwd_rw),    32'h0);

    // Reset in the middle of an access
    i_valid = 1'b1; i_control_ma_wb = 7'b1011011; i_mem_addr = 32'h00000060; i_rd_num = 5'd2;
    @(posedge i_clk);
    #1;
    check("mid_req_up", 32'(o_bus_req), 32'h1);
    i_reset_n = 1'b0;
    #1;
    check("mid_rst_req",   32'(o_bus_req),  32'h0);
    check("mid_rst_valid", 32'(o_valid_wb), 32'h0);
    i_valid = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1; i_bus_ack = 1'b1; i_bus_rdata = 32'hCAFEF00D;
    @(posedge i_clk);
    #1;
    i_bus_ack = 1'b0;
    check("late_ack_req",   32'(o_bus_req),  32'h0);
    check("late_ack_valid", 32'(o_valid_wb), 32'h0);
    repeat (3) @(posedge i_clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/memory_access_hs.md
Name: memory_access_hs

Overview:
Next-generation MA stage of the MIPS pipeline. It sits between the EX/MA and MA/WB pipeline registers and talks to an external data-memory port through a req/ack handshake, so it tolerates variable memory latency by stalling upstream. It adds byte-enable store steering, sign/zero-extended load extraction and misalignment/bus-error exceptions. It keeps the combinational forwarding outputs to the EX short-circuit unit.

Parameters:
NB_DATA, 32, datapath width (multiple of 8)
NB_ADDR_REGISTERS, 5, register-number width
NB_ADDR_MEM, 32, byte-address width presented on the memory port
NB_CONTROL_MA, 5, MA control bits {mem_read, mem_write, addressing[1:0], signing}
NB_CONTROL_WB, 2, WB control bits {mem_to_reg, reg_write}; reg_write is bit 0
NB_CONTROL_MA_WB, NB_CONTROL_MA+NB_CONTROL_WB, combined control bus width

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous reset, active low
i_valid  in  1  EX/MA holds a valid instruction
i_control_ma_wb  in  NB_CONTROL_MA_WB  MSB..: mem_read, mem_write, addressing, signing, then WB bits
i_mem_addr  in  NB_DATA  ALU result (address, or result for non-memory ops)
i_mem_data  in  NB_DATA  store data (rt)
i_rd_num  in  NB_ADDR_REGISTERS  destination register
o_stall  out  1  hold EX/MA and earlier stages this cycle
o_bus_req  out  1  memory request, held until ack
o_bus_we  out  1  1 = write
o_bus_addr  out  NB_ADDR_MEM  word-aligned byte address (low log2(NB_DATA/8) bits zero)
o_bus_wdata  out  NB_DATA  lane-steered store data
o_bus_be  out  NB_DATA/8  byte enables
i_bus_ack  in  1  access complete this cycle
i_bus_rdata  in  NB_DATA  read word, valid with ack
i_bus_err  in  1  access error, valid with ack
o_valid_wb  out  1  MA/WB holds a valid instruction
o_control_wb  out  NB_CONTROL_WB  registered WB control
o_mem_r_data  out  NB_DATA  registered extracted load data
o_reg_data  out  NB_DATA  registered ALU result
o_reg_num  out  NB_ADDR_REGISTERS  registered destination
o_exc  out  1  registered exception flag
o_exc_code  out  2  00 none, 01 misaligned load, 10 misaligned store, 11 bus error
o_ex_rd_num  out  NB_ADDR_REGISTERS  = i_rd_num (combinational)
o_ex_ctl_reg_write  out  1  = i_valid & reg_write & !mem_read (combinational)
o_ex_rd_data  out  NB_DATA  = i_mem_addr (combinational)

Behaviour:
- Reset (async, i_reset_n=0): state IDLE; o_bus_req, o_bus_we, o_bus_be, o_valid_wb, o_control_wb, o_exc, o_exc_code = 0; data regs (bus addr/wdata, o_mem_r_data, o_reg_data, o_reg_num) = 0. Reset mid-access drops the request immediately; a late ack is ignored in IDLE.
- Addressing: 00 byte, 01 half, 11 word; 10 is treated as word. Misaligned: half with addr[0]=1, word with addr[1:0]!=0.
- FSM IDLE: non-memory or !i_valid -> MA/WB loads next edge (1-cycle latency), o_stall=0. Misaligned memory op -> no request; MA/WB loads with o_exc=1, code 01/10, o_control_wb reg_write forced 0, o_stall=0. Aligned memory op -> o_stall=1, latch addr/wdata/be/control/rd, go REQ; o_valid_wb=0 next cycle (bubble).
- FSM REQ: o_bus_req=1, outputs stable. o_stall = !i_bus_ack. On ack: MA/WB loads from latched fields plus extracted rdata, o_valid_wb=1; if i_bus_err, o_exc=1, code 11, reg_write forced 0; go IDLE. Minimum memory op latency 2 cycles (ack in first REQ cycle).
- Store steering: byte -> data[7:0] replicated to all lanes, be = one-hot of addr[1:0]; half -> data[15:0] replicated, be = 0011/1100 by addr[1]; word -> be=1111.
- Load extraction: select lane by latched addr low bits; signing=1 sign-extends, 0 zero-extends; word passes through.
- While o_stall=1 upstream inputs are held; the block uses only latched values in REQ.
- o_bus_we=1 only for writes; mem_read and mem_write both set is treated as write.

Decomposition:
- Package ma_pkg: addressing codes, exc codes, control-bus bit indices, state encoding.
- Sub-module ma_lane_align: combinational store steering/byte enables and load extraction/extension.

Test Plan:
- ALU op, rd=5, addr=0x1234, reg_write=1 -> next cycle o_valid_wb=1, o_reg_data=0x1234, o_reg_num=5, o_stall never high.
- Word load addr 0x40, ack after 3 REQ cycles, rdata 0xDEADBEEF -> o_stall high 4 cycles, o_bus_addr=0x40, then o_mem_r_data=0xDEADBEEF.
- Signed byte load addr 0x43, rdata 0x80112233 -> o_bus_be unused, o_mem_r_data=0xFFFFFF80; unsigned -> 0x00000080.
- Half store addr 0x12, data 0x0000ABCD -> o_bus_be=1100, o_bus_wdata=0xABCDABCD, o_bus_we=1.
- Word load addr 0x41 -> no o_bus_req, o_exc=1, code 01, reg_write=0; ack with i_bus_err on load -> code 11.
- Deassert i_reset_n during REQ -> o_bus_req drops immediately, o_valid_wb=0, later ack ignored.
